debug_trace_receiver: RTL and testbench

- Host/bench-side receiver for the serial stream produced by the debug trace capture block.
- Deserializes 8N1 UART bytes from uart_rx and reassembles them into CAPTURE_WIDTH_BITS-wide capture records.
- Presents each complete record with a one-cycle valid pulse, so the testbench can check trace dumps on-chip without an external terminal.

---
 rtl/debug_trace_receiver.sv | 167 ++++++++++++++++
 tb/tb_debug_trace_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_receiver.sv
// UART 8N1 receiver that reassembles LSB-first byte streams into fixed-width capture
// records, flagging framing errors and dropping stale partial records after an idle timeout.
module debug_trace_receiver #(
  parameter int unsigned CAPTURE_WIDTH_BITS = 88,
  parameter int unsigned BAUD_DIVIDE        = 434,
  parameter int unsigned IDLE_TIMEOUT       = 65536
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic                          record_valid,
  output logic [CAPTURE_WIDTH_BITS-1:0] record_data,
  output logic                          frame_error,
  output logic                          partial_drop,
  output logic [31:0]                   record_count
);

  localparam int unsigned Bytes = (CAPTURE_WIDTH_BITS + 7) / 8;
  localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int unsigned CntW  = $clog2(BAUD_DIVIDE);
  localparam int unsigned IdleW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [CntW-1:0]  HalfLoad = CntW'(BAUD_DIVIDE / 2 - 1);
  localparam logic [CntW-1:0]  FullLoad = CntW'(BAUD_DIVIDE - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(Bytes - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic                          sync1_q, rx_s_q;
  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [2:0]                    bit_idx_q, bit_idx_d;
  logic [7:0]                    shreg_q, shreg_d;
  logic [IdxW-1:0]               byte_idx_q, byte_idx_d;
  logic [IdleW-1:0]              idle_q, idle_d;
  logic [Bytes*8-1:0]            asm_q, asm_d;
  logic                          record_valid_q, record_valid_d;
  logic [CAPTURE_WIDTH_BITS-1:0] record_data_q, record_data_d;
  logic                          frame_error_q, frame_error_d;
  logic                          partial_drop_q, partial_drop_d;
  logic [31:0]                   record_count_q, record_count_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shreg_d        = shreg_q;
    byte_idx_d     = byte_idx_q;
    idle_d         = idle_q;
    asm_d          = asm_q;
    record_valid_d = 1'b0;
    record_data_d  = record_data_q;
    frame_error_d  = 1'b0;
    partial_drop_d = 1'b0;
    record_count_d = record_count_q;

    unique case (state_q)
      StIdle: begin
        // Idle time only matters while a partial record is waiting for more bytes
        if (byte_idx_q != '0) begin
          if (idle_q == IdleLast) begin
            byte_idx_d     = '0;
            partial_drop_d = 1'b1;
            idle_d         = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        if (!rx_s_q) begin
          cnt_d   = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s_q) begin
          cnt_d     = FullLoad;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          cnt_d     = FullLoad;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = shreg_q;
          idle_d  = '0;
          state_d = StIdle;
          if (byte_idx_q == LastIdx) begin
            byte_idx_d     = '0;
            record_valid_d = 1'b1;
            record_data_d  = asm_d[CAPTURE_WIDTH_BITS-1:0];
            record_count_d = record_count_q + 32'd1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end else begin
          frame_error_d  = 1'b1;
          partial_drop_d = (byte_idx_q != '0);
          byte_idx_d     = '0;
          idle_d         = '0;
          state_d        = StBreak;
        end
      end
      StBreak: begin
        // A held-low line must return high before the next start bit counts
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= 1'b1;
      rx_s_q         <= 1'b1;
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shreg_q        <= '0;
      byte_idx_q     <= '0;
      idle_q         <= '0;
      asm_q          <= '0;
      record_valid_q <= 1'b0;
      record_data_q  <= '0;
      frame_error_q  <= 1'b0;
      partial_drop_q <= 1'b0;
      record_count_q <= '0;
    end else begin
      sync1_q        <= uart_rx;
      rx_s_q         <= sync1_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shreg_q        <= shreg_d;
      byte_idx_q     <= byte_idx_d;
      idle_q         <= idle_d;
      asm_q          <= asm_d;
      record_valid_q <= record_valid_d;
      record_data_q  <= record_data_d;
      frame_error_q  <= frame_error_d;
      partial_drop_q <= partial_drop_d;
      record_count_q <= record_count_d;
    end
  end

  assign record_valid = record_valid_q;
  assign record_data  = record_data_q;
  assign frame_error  = frame_error_q;
  assign partial_drop = partial_drop_q;
  assign record_count = record_count_q;

endmodule

// File: tb/tb_debug_trace_receiver.sv
// Scoreboarded bench for debug_trace_receiver: a byte-level model predicts records and
// error pulses with their arrival cycles; a negedge monitor pops and compares them.
module tb_debug_trace_receiver;

  localparam int unsigned W  = 88;
  localparam int unsigned B  = 8;
  localparam int unsigned TO = 100;
  localparam int unsigned NB = (W + 7) / 8;
  // Edges from start-bit launch to stop-bit sample: 2 sync + 1 detect + B/2 start + 9B
  localparam int unsigned StopLat = 3 + B / 2 + 9 * B;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          uart_rx = 1'b1;
  logic          record_valid;
  logic [W-1:0]  record_data;
  logic          frame_error;
  logic          partial_drop;
  logic [31:0]   record_count;

  debug_trace_receiver #(
    .CAPTURE_WIDTH_BITS(W),
    .BAUD_DIVIDE       (B),
    .IDLE_TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .record_valid(record_valid),
    .record_data (record_data),
    .frame_error (frame_error),
    .partial_drop(partial_drop),
    .record_count(record_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  count;
    int unsigned  at;
  } rec_t;

  rec_t        exp_rec_q[$];
  int unsigned exp_fe_q[$];
  int unsigned exp_pd_q[$];
  logic [7:0]  pend_q[$];
  int unsigned model_count = 0;
  int unsigned last_s = 0;
  logic [W-1:0] last_data = '0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  rec_t        mon_rec;
  int unsigned mon_at;
  always @(negedge clk) begin
    if (!reset) begin
      if (record_valid) begin
        check("record_expected", 128'(exp_rec_q.size() != 0), 128'd1);
        if (exp_rec_q.size() != 0) begin
          mon_rec = exp_rec_q.pop_front();
          check("record_data", 128'(record_data), 128'(mon_rec.data));
          check("record_count", 128'(record_count), 128'(mon_rec.count));
          check("record_cycle", 128'(cyc), 128'(mon_rec.at));
        end
      end
      if (frame_error) begin
        check("frame_error_expected", 128'(exp_fe_q.size() != 0), 128'd1);
        if (exp_fe_q.size() != 0) begin
          mon_at = exp_fe_q.pop_front();
          check("frame_error_cycle", 128'(cyc), 128'(mon_at));
        end
      end
      if (partial_drop) begin
        check("partial_drop_expected", 128'(exp_pd_q.size() != 0), 128'd1);
        if (exp_pd_q.size() != 0) begin
          mon_at = exp_pd_q.pop_front();
          check("partial_drop_cycle", 128'(cyc), 128'(mon_at));
        end
      end
    end
  end

  // Stimulus helpers; all are entered and left on a negedge
  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (B) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    int unsigned s = cyc + StopLat;
    logic [NB*8-1:0] full;
    if (stop_ok) begin
      pend_q.push_back(d);
      last_s = s;
      if (pend_q.size() == NB) begin
        full = '0;
        for (int i = 0; i < NB; i++) full[8*i +: 8] = pend_q[i];
        model_count++;
        last_data = full[W-1:0];
        exp_rec_q.push_back('{data: full[W-1:0], count: model_count, at: s});
        pend_q.delete();
      end
    end else begin
      exp_fe_q.push_back(s);
      if (pend_q.size() != 0) exp_pd_q.push_back(s);
      pend_q.delete();
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_ok);
  endtask

  // Line high for n cycles; a pending partial record is dropped once the gap reaches the limit
  task automatic line_idle(input int unsigned n);
    if (pend_q.size() != 0 && last_s + TO <= cyc + n + 3) begin
      exp_pd_q.push_back(last_s + TO);
      pend_q.delete();
    end
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_record(input logic [W-1:0] d, input int unsigned gmax);
    logic [NB*8-1:0] full;
    full = '0;
    full[W-1:0] = d;
    for (int i = 0; i < NB; i++) begin
      send_byte(full[8*i +: 8], 1'b1);
      if (i != NB - 1 && gmax != 0) line_idle($urandom_range(gmax, 0));
    end
  endtask

  function automatic logic [W-1:0] rand_rec();
    logic [NB*8-1:0] t;
    for (int i = 0; i < NB; i++) t[8*i +: 8] = 8'($urandom);
    return t[W-1:0];
  endfunction

  task automatic glitch();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    line_idle(2 * B);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_record_valid"}, 128'(record_valid), 128'd0);
    check({tag, "_record_data"}, 128'(record_data), 128'd0);
    check({tag, "_frame_error"}, 128'(frame_error), 128'd0);
    check({tag, "_partial_drop"}, 128'(partial_drop), 128'd0);
    check({tag, "_record_count"}, 128'(record_count), 128'd0);
  endtask

  logic [W-1:0] seq_rec;

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    line_idle(10);

    // Single record with bytes 0x01..0x0B
    for (int i = 0; i < NB; i++) seq_rec[8*i +: 8] = 8'(i + 1);
    send_record(seq_rec, 0);
    line_idle(20);

    // Two records back to back, zero idle anywhere
    send_record(rand_rec(), 0);
    send_record(rand_rec(), 0);
    line_idle(20);

    // Short low pulse must not start a byte
    glitch();
    send_record(rand_rec(), 0);
    line_idle(20);

    // Framing error after three good bytes, then a clean record
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    send_byte(8'h55, 1'b0);
    line_idle(20);
    send_record(rand_rec(), 0);
    line_idle(20);

    // Partial record of five bytes times out
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    line_idle(TO);
    send_record(rand_rec(), 0);
    line_idle(20);

    // Reset in the middle of the sixth byte
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    reset = 1'b1;
    #1 check_outputs_zero("midreset");
    pend_q.delete();
    model_count = 0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    line_idle(2 * B);
    send_record(rand_rec(), 0);
    line_idle(20);

    // Random traffic with small inter-byte gaps and occasional glitches
    for (int r = 0; r < 5; r++) begin
      if ($urandom_range(1, 0) == 1) glitch();
      send_record(rand_rec(), 5);
      line_idle($urandom_range(6, 0));
    end

    line_idle(50);
    check("records_outstanding", 128'(exp_rec_q.size()), 128'd0);
    check("frame_errors_outstanding", 128'(exp_fe_q.size()), 128'd0);
    check("partial_drops_outstanding", 128'(exp_pd_q.size()), 128'd0);
    check("final_record_count", 128'(record_count), 128'(model_count));
    check("final_record_data_held", 128'(record_data), 128'(last_data));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
